// File: rtl/led_pattern_driver.sv
// One-hot LED front-end: direct select, chase, bounce and blink patterns,
// with the auto-advancing patterns paced by a prescaler.
module led_pattern_driver #(
    parameter int unsigned SEL_W    = 2,
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned CNT_W    = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic [1:0]              mode,
    input  logic [SEL_W-1:0]        sel,
    output logic [(2**SEL_W)-1:0]   led,
    output logic [SEL_W-1:0]        pos,
    output logic                    tick
);

    localparam int unsigned N = 2**SEL_W;
    localparam logic [SEL_W-1:0] POS_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_CHASE  = 2'd1,
        MODE_BOUNCE = 2'd2,
        MODE_BLINK  = 2'd3
    } mode_e;

    mode_e            mode_q, mode_d;
    logic [SEL_W-1:0] pos_q, pos_d;
    logic             dir_q, dir_d;
    logic             phase_q, phase_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [N-1:0]     led_q, led_d;
    logic             tick_int_c;

    assign tick_int_c = en && (cnt_q == CNT_LAST);

    // Next-state: a mode change restarts the pattern and suppresses any step.
    always_comb begin
        mode_d  = mode_q;
        pos_d   = pos_q;
        dir_d   = dir_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;

        if (mode != mode_q) begin
            mode_d  = mode_e'(mode);
            cnt_d   = '0;
            pos_d   = sel;
            dir_d   = 1'b1;
            phase_d = 1'b1;
        end else begin
            tick_d = tick_int_c;
            if (en) begin
                cnt_d = tick_int_c ? '0 : cnt_q + CNT_W'(1);
            end
            unique case (mode_q)
                MODE_DIRECT: begin
                    pos_d   = sel;
                    phase_d = 1'b1;
                end
                MODE_CHASE: begin
                    phase_d = 1'b1;
                    if (tick_int_c) begin
                        pos_d = pos_q + SEL_W'(1);
                    end
                end
                MODE_BOUNCE: begin
                    phase_d = 1'b1;
                    if (tick_int_c) begin
                        if (dir_q && (pos_q == POS_MAX)) begin
                            dir_d = 1'b0;
                            pos_d = POS_MAX - SEL_W'(1);
                        end else if (!dir_q && (pos_q == '0)) begin
                            dir_d = 1'b1;
                            pos_d = SEL_W'(1);
                        end else if (dir_q) begin
                            pos_d = pos_q + SEL_W'(1);
                        end else begin
                            pos_d = pos_q - SEL_W'(1);
                        end
                    end
                end
                MODE_BLINK: begin
                    pos_d = sel;
                    if (tick_int_c) begin
                        phase_d = !phase_q;
                    end
                end
            endcase
        end

        // LED flops mirror the decode of the next pos/phase, so led stays in step with pos.
        led_d = phase_d ? (N'(1) << pos_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_DIRECT;
            pos_q   <= '0;
            dir_q   <= 1'b1;
            phase_q <= 1'b1;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            led_q   <= N'(1);
        end else begin
            mode_q  <= mode_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign pos  = pos_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver: three configurations share one stimulus stream
// and are compared every cycle against a pattern-level reference model.
module tb_led_pattern_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [1:0] sel  = 2'd0;

    logic [3:0] led0, led2;
    logic [1:0] led1;
    logic [1:0] pos0, pos2;
    logic [0:0] pos1;
    logic       tick0, tick1, tick2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    led_pattern_driver #(.SEL_W(2), .TICK_DIV(4), .CNT_W(24)) u_dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .led(led0), .pos(pos0), .tick(tick0));

    led_pattern_driver #(.SEL_W(1), .TICK_DIV(4), .CNT_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[0:0]),
        .led(led1), .pos(pos1), .tick(tick1));

    led_pattern_driver #(.SEL_W(2), .TICK_DIV(1), .CNT_W(1)) u_dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
        .led(led2), .pos(pos2), .tick(tick2));

    // Reference model, per instance: LED count, tick period, pattern state.
    int n_leds[3] = '{4, 2, 4};
    int t_div[3]  = '{4, 4, 1};
    int m_mode[3], m_pos[3], m_bidx[3], m_cnt[3];
    bit m_phase[3], m_tick[3];

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bounce is modelled as a walk round a cycle of length 2N-2 folded onto 0..N-1.
    function automatic int fold(input int idx, input int n);
        return (idx < n) ? idx : (2 * n - 2 - idx);
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            int  s;
            bit  step;
            s = (i == 1) ? int'(sel[0]) : int'(sel);
            if (rst) begin
                m_mode[i] = 0; m_pos[i] = 0; m_bidx[i] = 0;
                m_cnt[i] = 0; m_phase[i] = 1'b1; m_tick[i] = 1'b0;
            end else if (int'(mode) != m_mode[i]) begin
                m_mode[i] = int'(mode); m_pos[i] = s; m_bidx[i] = s;
                m_cnt[i] = 0; m_phase[i] = 1'b1; m_tick[i] = 1'b0;
            end else begin
                step = en && (m_cnt[i] == t_div[i] - 1);
                m_tick[i] = step;
                if (en) m_cnt[i] = (m_cnt[i] + 1) % t_div[i];
                case (m_mode[i])
                    0: begin m_pos[i] = s; m_phase[i] = 1'b1; end
                    1: if (step) m_pos[i] = (m_pos[i] + 1) % n_leds[i];
                    2: if (step) begin
                        m_bidx[i] = (m_bidx[i] + 1) % (2 * n_leds[i] - 2);
                        m_pos[i]  = fold(m_bidx[i], n_leds[i]);
                    end
                    default: begin
                        m_pos[i] = s;
                        if (step) m_phase[i] = !m_phase[i];
                    end
                endcase
            end
        end
    end

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            int gl, gp, gt, el;
            case (i)
                0:       begin gl = int'(led0); gp = int'(pos0); gt = int'(tick0); end
                1:       begin gl = int'(led1); gp = int'(pos1); gt = int'(tick1); end
                default: begin gl = int'(led2); gp = int'(pos2); gt = int'(tick2); end
            endcase
            el = m_phase[i] ? (1 << m_pos[i]) : 0;
            check_val($sformatf("u%0d_led", i),  gl, el);
            check_val($sformatf("u%0d_pos", i),  gp, m_pos[i]);
            check_val($sformatf("u%0d_tick", i), gt, int'(m_tick[i]));
        end
    endtask

    task automatic cycles(input int k);
        for (int c = 0; c < k; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_all();
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_pos[i] = 0; m_bidx[i] = 0;
            m_cnt[i] = 0; m_phase[i] = 1'b1; m_tick[i] = 1'b0;
        end

        // Reset and direct decode
        rst = 1'b1; en = 1'b0; mode = 2'd0; sel = 2'd0;
        cycles(2);
        check_val("rst_led", int'(led0), 1);
        check_val("rst_pos", int'(pos0), 0);
        rst = 1'b0; sel = 2'd2;
        cycles(1);
        check_val("direct_sel2", int'(led0), 4);
        sel = 2'd3;
        cycles(1);
        check_val("direct_sel3", int'(led0), 8);
        en = 1'b1; cycles(3); en = 1'b0; cycles(3);

        // Chase from index 2 with wrap
        sel = 2'd2; en = 1'b1; mode = 2'd1;
        cycles(1);
        check_val("chase_entry", int'(led0), 4);
        sel = 2'd0;
        cycles(4);
        check_val("chase_step1", int'(led0), 8);
        cycles(4);
        check_val("chase_wrap", int'(led0), 1);
        cycles(12);

        // Bounce from 0 through both endpoints
        mode = 2'd2; sel = 2'd0;
        cycles(36);

        // Blink with enable hold and sel change during the off phase
        mode = 2'd3; sel = 2'd1;
        cycles(6);
        check_val("blink_off", int'(led0), 0);
        en = 1'b0; cycles(10);
        check_val("blink_hold", int'(led0), 0);
        sel = 2'd3; en = 1'b1;
        cycles(1);
        check_val("blink_sel_off", int'(led0), 0);
        cycles(3);
        check_val("blink_on_sel3", int'(led0), 8);
        cycles(8);

        // Reset mid-bounce while moving down, then restart upward from sel
        mode = 2'd2; sel = 2'd0;
        cycles(18);
        rst = 1'b1;
        cycles(1);
        check_val("rst_mid_led", int'(led0), 1);
        rst = 1'b0; sel = 2'd1;
        cycles(30);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            en  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0)  sel  = 2'($urandom_range(0, 3));
            cycles(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
